// File: rtl/save_pkg.sv
// save_pkg: shared constants for the save/respawn controller.
// Holds the FSM state encoding, the coordinate width and the
// save-point position tables used by save_ctrl and save_hit_detect.
package save_pkg;

   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      DEAD    = 2'd1,
      RESPAWN = 2'd2
   } save_state_e;

   // Save-point x position table; unknown indices map to the origin.
   function automatic logic [COORD_W-1:0] save_x_of(input int p);
      logic [COORD_W-1:0] x_s;
      case (p)
         32'sd0:  x_s = 10'd95;
         32'sd1:  x_s = 10'd480;
         default: x_s = 10'd0;
      endcase
      return x_s;
   endfunction

   // Save-point y position table; unknown indices map to the origin.
   function automatic logic [COORD_W-1:0] save_y_of(input int p);
      logic [COORD_W-1:0] y_s;
      case (p)
         32'sd0:  y_s = 10'd320;
         32'sd1:  y_s = 10'd128;
         default: y_s = 10'd0;
      endcase
      return y_s;
   endfunction

endpackage

// File: rtl/save_hit_detect.sv
// save_hit_detect: tests every bullet slot against one save-point box.
// The box is grown by one pixel on every side; compares run on 11-bit
// zero-extended operands so neither bound can wrap. The lower bound is
// written as (v + 1 >= base) so a box at coordinate 0 stays correct.
module save_hit_detect
   import save_pkg::*;
#(
   parameter int NUM_BULLETS = 4,
   parameter int SAVE_W      = 32,
   parameter int SAVE_H      = 32
) (
   input  logic [COORD_W-1:0]             point_x,
   input  logic [COORD_W-1:0]             point_y,
   input  logic [COORD_W*NUM_BULLETS-1:0] bullet_x,
   input  logic [COORD_W*NUM_BULLETS-1:0] bullet_y,
   input  logic [NUM_BULLETS-1:0]         bullet_valid,
   output logic                           hit
);

   localparam int EXT_W = COORD_W + 1;

   logic [EXT_W-1:0]       px_s;
   logic [EXT_W-1:0]       py_s;
   logic [EXT_W-1:0]       x_hi_s;
   logic [EXT_W-1:0]       y_hi_s;
   logic [NUM_BULLETS-1:0] slot_hit_s;

   assign px_s   = {1'b0, point_x};
   assign py_s   = {1'b0, point_y};
   assign x_hi_s = px_s + EXT_W'(SAVE_W + 1);
   assign y_hi_s = py_s + EXT_W'(SAVE_H + 1);

   // Per-slot inclusion test against the expanded box.
   always_comb begin
      slot_hit_s = '0;
      for (int b = 0; b < NUM_BULLETS; b++) begin
         slot_hit_s[b] = bullet_valid[b]
            && (({1'b0, bullet_x[b*COORD_W +: COORD_W]} + EXT_W'(1)) >= px_s)
            && ({1'b0, bullet_x[b*COORD_W +: COORD_W]} < x_hi_s)
            && (({1'b0, bullet_y[b*COORD_W +: COORD_W]} + EXT_W'(1)) >= py_s)
            && ({1'b0, bullet_y[b*COORD_W +: COORD_W]} < y_hi_s);
      end
   end

   assign hit = |slot_hit_s;

endmodule

// File: rtl/save_ctrl.sv
// save_ctrl: save/respawn controller.
// Selects the active save point from bullet hits, latches the kid's
// position as the respawn point and sequences PLAY -> DEAD -> RESPAWN.
// Optional feature macro: SAVE_CTRL_DEATH_CNT_EN builds the saturating
// 16-bit death counter; without it death_count is tied to zero.
module save_ctrl
   import save_pkg::*;
#(
   parameter int NUM_SAVES   = 2,
   parameter int NUM_BULLETS = 4,
   parameter int SAVE_W      = 32,
   parameter int SAVE_H      = 32,
   parameter int INIT_X      = 40,
   parameter int INIT_Y      = 400,
   parameter int LOCK_FRAMES = 20
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_tick,
   input  logic [COORD_W-1:0]             kid_x,
   input  logic [COORD_W-1:0]             kid_y,
   input  logic                           kid_dead,
   input  logic                           restart,
   input  logic [COORD_W*NUM_BULLETS-1:0] bullet_x,
   input  logic [COORD_W*NUM_BULLETS-1:0] bullet_y,
   input  logic [NUM_BULLETS-1:0]         bullet_valid,
   output logic [NUM_SAVES-1:0]           save_sel,
   output logic [COORD_W-1:0]             spawn_x,
   output logic [COORD_W-1:0]             spawn_y,
   output logic                           respawn,
   output logic                           dead,
   output logic [15:0]                    death_count
);

   localparam int LOCK_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

   save_state_e          state_r;
   save_state_e          state_nxt_s;
   logic [NUM_SAVES-1:0] hit_s;
   logic [NUM_SAVES-1:0] first_hit_s;
   logic                 found_s;
   logic                 save_go_s;
   logic [LOCK_W-1:0]    lock_cnt_r;
   logic [NUM_SAVES-1:0] save_sel_r;
   logic [COORD_W-1:0]   spawn_x_r;
   logic [COORD_W-1:0]   spawn_y_r;
   logic                 respawn_r;
   logic                 dead_r;

   // One hit detector per save point, positioned from the package tables.
   for (genvar g = 0; g < NUM_SAVES; g++) begin : g_hit
      localparam logic [COORD_W-1:0] PX = save_x_of(g);
      localparam logic [COORD_W-1:0] PY = save_y_of(g);

      save_hit_detect #(
         .NUM_BULLETS (NUM_BULLETS),
         .SAVE_W      (SAVE_W),
         .SAVE_H      (SAVE_H)
      ) u_hit (
         .point_x      (PX),
         .point_y      (PY),
         .bullet_x     (bullet_x),
         .bullet_y     (bullet_y),
         .bullet_valid (bullet_valid),
         .hit          (hit_s[g])
      );
   end

   // Lowest-index hit point wins; result is one-hot or zero.
   always_comb begin
      first_hit_s = '0;
      found_s     = 1'b0;
      for (int p = 0; p < NUM_SAVES; p++) begin
         if (hit_s[p] && !found_s) begin
            first_hit_s[p] = 1'b1;
            found_s        = 1'b1;
         end else begin
            first_hit_s[p] = 1'b0;
         end
      end
   end

   // Save qualifier: only in PLAY, lock expired, and a death takes priority.
   always_comb begin
      if ((state_r == PLAY) && found_s && (lock_cnt_r == '0) && !kid_dead) begin
         save_go_s = 1'b1;
      end else begin
         save_go_s = 1'b0;
      end
   end

   // Next-state logic; kid_dead outranks restart while playing.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         PLAY: begin
            if (kid_dead) begin
               state_nxt_s = DEAD;
            end else if (restart) begin
               state_nxt_s = RESPAWN;
            end else begin
               state_nxt_s = PLAY;
            end
         end
         DEAD: begin
            if (restart) begin
               state_nxt_s = RESPAWN;
            end else begin
               state_nxt_s = DEAD;
            end
         end
         RESPAWN: state_nxt_s = PLAY;
         default: state_nxt_s = PLAY;
      endcase
   end

   // State register plus registered dead/respawn decodes of the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= PLAY;
         dead_r    <= 1'b0;
         respawn_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         dead_r    <= (state_nxt_s == DEAD);
         respawn_r <= (state_nxt_s == RESPAWN);
      end
   end

   // Save lock: cleared by a respawn, loaded on save, counts down per frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_cnt_r <= '0;
      end else if (state_r == RESPAWN) begin
         lock_cnt_r <= '0;
      end else if (save_go_s) begin
         lock_cnt_r <= LOCK_W'(LOCK_FRAMES);
      end else if (frame_tick && (lock_cnt_r != '0)) begin
         lock_cnt_r <= lock_cnt_r - LOCK_W'(1);
      end else begin
         lock_cnt_r <= lock_cnt_r;
      end
   end

   // Active save point and respawn position; persist until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         save_sel_r <= '0;
         spawn_x_r  <= COORD_W'(INIT_X);
         spawn_y_r  <= COORD_W'(INIT_Y);
      end else if (save_go_s) begin
         save_sel_r <= first_hit_s;
         spawn_x_r  <= kid_x;
         spawn_y_r  <= kid_y;
      end else begin
         save_sel_r <= save_sel_r;
         spawn_x_r  <= spawn_x_r;
         spawn_y_r  <= spawn_y_r;
      end
   end

`ifdef SAVE_CTRL_DEATH_CNT_EN
   logic [15:0] death_cnt_r;

   // Counts deaths accepted in PLAY, holding at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         death_cnt_r <= 16'd0;
      end else if ((state_r == PLAY) && kid_dead && (death_cnt_r != 16'hFFFF)) begin
         death_cnt_r <= death_cnt_r + 16'd1;
      end else begin
         death_cnt_r <= death_cnt_r;
      end
   end

   assign death_count = death_cnt_r;
`else
   assign death_count = 16'd0;
`endif

   assign save_sel = save_sel_r;
   assign spawn_x  = spawn_x_r;
   assign spawn_y  = spawn_y_r;
   assign respawn  = respawn_r;
   assign dead     = dead_r;

endmodule

// File: tb/tb_save_ctrl.sv
// tb_save_ctrl: self-checking bench for save_ctrl.
// Directed table of per-row stimulus and expected outputs, a hand-written
// reset-while-dead sequence, then randomized stimulus against a model.
module tb_save_ctrl;

`ifdef SAVE_CTRL_DEATH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int NB   = 4;
   localparam int NS   = 2;
   localparam int LOCK = 20;
   localparam int BW   = 32;
   localparam int BH   = 32;

   int PXS [NS] = '{95, 480};
   int PYS [NS] = '{320, 128};

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_tick;
   logic [9:0]    kid_x, kid_y;
   logic          kid_dead, restart;
   logic [10*NB-1:0] bullet_x, bullet_y;
   logic [NB-1:0] bullet_valid;
   logic [NS-1:0] save_sel;
   logic [9:0]    spawn_x, spawn_y;
   logic          respawn, dead;
   logic [15:0]   death_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   save_ctrl #(
      .NUM_SAVES(NS), .NUM_BULLETS(NB), .SAVE_W(BW), .SAVE_H(BH),
      .INIT_X(40), .INIT_Y(400), .LOCK_FRAMES(LOCK)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .kid_x(kid_x), .kid_y(kid_y), .kid_dead(kid_dead), .restart(restart),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_valid(bullet_valid),
      .save_sel(save_sel), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .respawn(respawn), .dead(dead), .death_count(death_count)
   );

   typedef struct {
      int n;   bit tick; bit kd; bit rs;
      int kx;  int ky;
      int b0x; int b0y;   // slot 0, negative x means slot idle
      int b2x; int b2y;   // slot 2, negative x means slot idle
      int e_sel; int e_sx; int e_sy; bit e_resp; bit e_dead; int e_dc;
   } vec_t;

   vec_t tbl[$];

   // model state
   int m_sel, m_sx, m_sy, m_lock, m_deaths;
   bit m_dead, m_resp;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int e_sel, input int e_sx,
                            input int e_sy, input bit e_resp, input bit e_dead,
                            input int e_dc);
      check({tag, " save_sel"}, 32'(save_sel), e_sel);
      check({tag, " spawn_x"}, 32'(spawn_x), e_sx);
      check({tag, " spawn_y"}, 32'(spawn_y), e_sy);
      check({tag, " respawn"}, 32'(respawn), int'(e_resp));
      check({tag, " dead"}, 32'(dead), int'(e_dead));
      check({tag, " death_count"}, 32'(death_count), CNT_EN ? e_dc : 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      frame_tick   = 1'b0;
      kid_dead     = 1'b0;
      restart      = 1'b0;
      bullet_valid = '0;
      bullet_x     = '0;
      bullet_y     = '0;
   endtask

   task automatic set_bullet(input int slot, input int x, input int y);
      bullet_x[slot*10 +: 10] = 10'(x);
      bullet_y[slot*10 +: 10] = 10'(y);
      bullet_valid[slot]      = 1'b1;
   endtask

   task automatic add(input int n, input bit tick, input bit kd, input bit rs,
                      input int kx, input int ky, input int b0x, input int b0y,
                      input int b2x, input int b2y, input int e_sel, input int e_sx,
                      input int e_sy, input bit e_resp, input bit e_dead, input int e_dc);
      vec_t v;
      v.n = n; v.tick = tick; v.kd = kd; v.rs = rs; v.kx = kx; v.ky = ky;
      v.b0x = b0x; v.b0y = b0y; v.b2x = b2x; v.b2y = b2y;
      v.e_sel = e_sel; v.e_sx = e_sx; v.e_sy = e_sy;
      v.e_resp = e_resp; v.e_dead = e_dead; v.e_dc = e_dc;
      tbl.push_back(v);
   endtask

   function automatic bit point_hit(input int p);
      bit h;
      int x, y;
      h = 1'b0;
      for (int b = 0; b < NB; b++) begin
         x = int'(bullet_x[b*10 +: 10]);
         y = int'(bullet_y[b*10 +: 10]);
         if (bullet_valid[b] && x >= PXS[p] - 1 && x < PXS[p] + BW + 1 &&
             y >= PYS[p] - 1 && y < PYS[p] + BH + 1)
            h = 1'b1;
      end
      return h;
   endfunction

   task automatic model_reset();
      m_sel = -1; m_sx = 40; m_sy = 400; m_lock = 0; m_deaths = 0;
      m_dead = 1'b0; m_resp = 1'b0;
   endtask

   // Advance the model across one clock edge using the current inputs.
   task automatic model_edge();
      int first;
      bit playing, save;
      first = -1;
      for (int p = NS - 1; p >= 0; p--)
         if (point_hit(p)) first = p;
      playing = !m_dead && !m_resp;
      save = playing && first >= 0 && m_lock == 0 && !kid_dead;
      if (m_resp) m_lock = 0;
      else if (save) m_lock = LOCK;
      else if (frame_tick && m_lock > 0) m_lock = m_lock - 1;
      if (save) begin
         m_sel = first; m_sx = int'(kid_x); m_sy = int'(kid_y);
      end
      if (m_resp) m_resp = 1'b0;
      else if (m_dead) begin
         if (restart) begin m_dead = 1'b0; m_resp = 1'b1; end
      end else if (kid_dead) begin
         m_dead = 1'b1;
         if (m_deaths < 65535) m_deaths = m_deaths + 1;
      end else if (restart) m_resp = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      kid_x = '0; kid_y = '0;
      idle_inputs();
      step(); step();
      check_all("reset", 0, 40, 400, 1'b0, 1'b0, 0);
      rst = 1'b1;

      //  n tk kd rs  kx   ky   b0x  b0y  b2x  b2y  sel  sx   sy  rsp dd dc
      add(1, 0, 0, 0,  61, 351,  -1,  -1, 128, 353,  0,  40, 400, 0, 0, 0);
      add(1, 1, 0, 0,  60, 350,  -1,  -1,  94, 319,  1,  60, 350, 0, 0, 0);
      add(5, 1, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  60, 350, 0, 0, 0);
      add(1, 0, 0, 0, 300, 200, 480, 128,  -1,  -1,  1,  60, 350, 0, 0, 0);
      add(14,1, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  60, 350, 0, 0, 0);
      add(1, 0, 0, 0, 300, 200, 480, 128,  -1,  -1,  1,  60, 350, 0, 0, 0);
      add(1, 1, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  60, 350, 0, 0, 0);
      add(1, 0, 0, 0, 500, 100, 512, 160,  -1,  -1,  2, 500, 100, 0, 0, 0);
      add(20,1, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  2, 500, 100, 0, 0, 0);
      add(1, 0, 0, 0,  11,  22, 490, 140, 100, 330,  1,  11,  22, 0, 0, 0);
      add(20,1, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 0, 0);
      add(1, 0, 1, 0,  33,  44, 490, 140,  -1,  -1,  1,  11,  22, 0, 1, 1);
      add(1, 0, 1, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 1, 1);
      add(1, 0, 0, 0,  77,  88, 490, 140,  -1,  -1,  1,  11,  22, 0, 1, 1);
      add(1, 0, 0, 1,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 1, 0, 1);
      add(1, 0, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 0, 1);
      add(1, 0, 0, 1,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 1, 0, 1);
      add(1, 0, 0, 1,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 0, 1);
      add(1, 0, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 0, 1);
      add(1, 0, 1, 1,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 1, 2);
      add(1, 0, 0, 1,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 1, 0, 2);
      add(1, 0, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 0, 2);
      add(1, 0, 1, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 1, 3);
      add(1, 0, 0, 1,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 1, 0, 3);
      add(1, 0, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  1,  11,  22, 0, 0, 3);
      add(1, 0, 0, 0,   1,   2, 490, 140,  -1,  -1,  2,   1,   2, 0, 0, 3);
      add(1, 0, 0, 1,   5,   6, 490, 140,  -1,  -1,  2,   1,   2, 1, 0, 3);
      add(1, 0, 0, 0,   0,   0,  -1,  -1,  -1,  -1,  2,   1,   2, 0, 0, 3);
      add(1, 0, 0, 0,   3,   4,  -1,  -1, 100, 330,  1,   3,   4, 0, 0, 3);

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            idle_inputs();
            frame_tick = tbl[i].tick;
            kid_dead   = tbl[i].kd;
            restart    = tbl[i].rs;
            kid_x      = 10'(tbl[i].kx);
            kid_y      = 10'(tbl[i].ky);
            if (tbl[i].b0x >= 0) set_bullet(0, tbl[i].b0x, tbl[i].b0y);
            if (tbl[i].b2x >= 0) set_bullet(2, tbl[i].b2x, tbl[i].b2y);
            step();
         end
         idle_inputs();
         check_all($sformatf("row%0d", i), tbl[i].e_sel, tbl[i].e_sx, tbl[i].e_sy,
                   tbl[i].e_resp, tbl[i].e_dead, tbl[i].e_dc);
      end

      // reset while in DEAD: aborts at once, no respawn afterwards
      kid_dead = 1'b1;
      step();
      kid_dead = 1'b0;
      check("pre-reset dead", 32'(dead), 1);
      rst = 1'b0;
      #2;
      check_all("async reset", 0, 40, 400, 1'b0, 1'b0, 0);
      step();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("post-reset respawn%0d", k), 32'(respawn), 0);
         check($sformatf("post-reset dead%0d", k), 32'(dead), 0);
      end

      // randomized run against the model
      rst = 1'b0;
      idle_inputs();
      step();
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 3000 && n_err < 50; c++) begin
         idle_inputs();
         frame_tick = ($urandom_range(0, 2) == 0);
         kid_dead   = ($urandom_range(0, 39) == 0);
         restart    = ($urandom_range(0, 24) == 0);
         kid_x      = 10'($urandom_range(0, 1023));
         kid_y      = 10'($urandom_range(0, 1023));
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 2) == 0) begin
               int p, x, y;
               p = int'($urandom_range(0, NS - 1));
               if ($urandom_range(0, 3) != 0) begin
                  x = PXS[p] - 3 + int'($urandom_range(0, BW + 6));
                  y = PYS[p] - 3 + int'($urandom_range(0, BH + 6));
               end else begin
                  x = int'($urandom_range(0, 1023));
                  y = int'($urandom_range(0, 1023));
               end
               set_bullet(b, x, y);
            end
         end
         model_edge();
         step();
         check_all($sformatf("rand%0d", c), (m_sel >= 0) ? (1 << m_sel) : 0,
                   m_sx, m_sy, m_resp, m_dead, m_deaths);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/save_ctrl.md
# save_ctrl

Save/respawn controller for the game core. It watches the live bullets against every save-point box, one-hot selects the active save point, and latches the kid's position as the respawn point. It sequences death → wait-for-restart → respawn, and drives each save-point sprite's "saved" look. It sits between the bullet manager, the kid physics block and the save-point sprite renderers.

## Interface
Parameters:
- NUM_SAVES, 2: number of save points; their positions come from the shared package tables.
- NUM_BULLETS, 4: bullet slots; 10-bit coordinates, packed.
- SAVE_W, 32: save-box width in pixels.
- SAVE_H, 32: save-box height in pixels.
- INIT_X, 40: spawn x applied at reset.
- INIT_Y, 400: spawn y applied at reset.
- LOCK_FRAMES, 20: frames during which new saves are ignored after a save.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- kid_x, kid_y  in  10 each  kid position.
- kid_dead  in  1  one-cycle death pulse from kid physics.
- restart  in  1  one-cycle pulse from the R key.
- bullet_x, bullet_y  in  10*NUM_BULLETS each  packed bullet coordinates; slot i is bits [10i+9:10i].
- bullet_valid  in  NUM_BULLETS  slot-live flags.
- save_sel  out  NUM_SAVES  one-hot active save point; all-zero when none is active.
- spawn_x, spawn_y  out  10 each  respawn coordinates.
- respawn  out  1  one-cycle pulse commanding the kid to spawn_x/spawn_y.
- dead  out  1  high while in DEAD.
- death_count  out  16  saturating death counter.

## Operation
- Hit test for point p and bullet b: the bullet is valid, SAVE_X[p]-1 ≤ x < SAVE_X[p]+SAVE_W+1, and SAVE_Y[p]-1 ≤ y < SAVE_Y[p]+SAVE_H+1.
  - Compares are unsigned on 11-bit extended operands, so the -1 and +W+1 bounds never wrap.
- hit[p] is the OR over all bullets.
- FSM states: PLAY, DEAD, RESPAWN. Reset state is PLAY.
- PLAY:
  - Save condition: any hit, and lock_cnt is 0, and kid_dead is 0.
  - On save: the lowest-index hit point wins. save_sel becomes one-hot of that point, clearing any other point. spawn_x/spawn_y latch kid_x/kid_y from the same cycle. lock_cnt loads LOCK_FRAMES.
  - Re-hitting the already-selected point re-latches the position and reloads the lock.
  - kid_dead → DEAD and death_count increments. kid_dead has priority over a save and over restart in the same cycle.
  - restart with no kid_dead → RESPAWN.
- DEAD:
  - Hits are ignored, and further kid_dead pulses are neither counted nor acted on.
  - restart → RESPAWN.
- RESPAWN: lasts exactly one cycle. respawn=1, lock_cnt clears, next state is PLAY.
- lock_cnt decrements on frame_tick while nonzero, in every state. It saturates at 0.
- save_sel and spawn_* persist through DEAD and RESPAWN. Only reset clears them.
- Reset values:
  - save_sel: 0.
  - spawn_x, spawn_y: INIT_X, INIT_Y.
  - respawn, dead: 0.
  - death_count, lock_cnt: 0.
  - state: PLAY.
- Reset asserted mid-sequence aborts immediately, with no respawn pulse.

## Timing
- All outputs are registered.
- Hit in cycle N → save_sel and spawn_* update at edge N+1.
- kid_dead in cycle N → dead=1 and death_count+1 visible after edge N+1.
- restart in cycle N (in DEAD or PLAY) → respawn=1 during cycle N+1, then dead=0 and state PLAY from edge N+2.
- restart during RESPAWN is ignored.
- A frame_tick in the save cycle does not decrement the freshly loaded lock.
- death_count saturates at 16'hFFFF.

## Configuration
- SAVE_CTRL_DEATH_CNT_EN defined: the 16-bit death counter is built as described.
- Not defined: the counter logic is removed and death_count is tied to 16'd0. Every other behaviour is identical.

## Structure
- Package save_pkg holds:
  - State encoding: PLAY=2'd0, DEAD=2'd1, RESPAWN=2'd2.
  - SAVE_X/SAVE_Y position tables; point 0 = (95, 320), point 1 = (480, 128).
  - The 10-bit coordinate width constant.
- Sub-module save_hit_detect: one instance per save point. It takes the point position and the packed bullets, and outputs a combinational hit bit. The top level holds the priority encode, FSM and counters.

## Test plan
- Reset → save_sel=0, spawn=(40,400), death_count=0, respawn=0, dead=0.
- Bullet 2 valid at (94,319), kid at (60,350) → next cycle save_sel=2'b01, spawn=(60,350). Bullet at (128,353) (exclusive right and bottom bound of the expanded box) → no save.
- Point 0 hit, then point 1 hit 5 frame_ticks later → ignored. Point 1 hit after 20 ticks → save_sel=2'b10, spawn re-latched. Both points hit in the same cycle → save_sel=2'b01.
- kid_dead and a hit in the same cycle → dead=1, death_count=1, save_sel unchanged. Second kid_dead while in DEAD → count stays 1. restart → one-cycle respawn with the saved spawn, then PLAY.
- restart in PLAY → respawn pulse, death_count unchanged. Reset asserted while in DEAD → state PLAY, dead=0, no respawn pulse.
- Built without SAVE_CTRL_DEATH_CNT_EN: three deaths → death_count stays 0; all other checks pass.
